// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: register-index width, $zero index, mult/div latency.
package mips_defs;
  localparam int          REG_W          = 5;
  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int unsigned MD_LATENCY_DEF = 32;

  // A source depends on a destination only if it is actually read and the destination is not $zero.
  function automatic logic reg_match(input logic use_src, input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return use_src && (dst != REG_ZERO) && (src == dst);
  endfunction
endpackage

// File: rtl/md_countdown.sv
// Tracks how long the HI/LO unit stays occupied after a mult/div issues.
module md_countdown
  import mips_defs::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_busy
);
  localparam int MDC_W = $clog2(MD_LATENCY + 1);

  logic [MDC_W-1:0] r_md_count;

  // A fresh issue restarts the countdown even if it lands on a decrementing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_count <= '0;
    end else if (i_load) begin
      r_md_count <= MDC_W'(MD_LATENCY);
    end else if (r_md_count != '0) begin
      r_md_count <= r_md_count - MDC_W'(1);
    end
  end

  assign o_busy = (r_md_count != '0);
endmodule

// File: rtl/hazard_stall_unit.sv
// Issue-side hazard detection: freezes PC/IF-ID and bubbles ID/EX for hazards forwarding cannot cover.
module hazard_stall_unit
  import mips_defs::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rsID,
  input  logic [REG_W-1:0] rtID,
  input  logic             useRsID,
  input  logic             useRtID,
  input  logic             branchID,
  input  logic             branchTakenID,
  input  logic             mdStartID,
  input  logic             hiloReadID,
  input  logic             regWriteEX,
  input  logic             memReadEX,
  input  logic [REG_W-1:0] writeRegEX,
  input  logic             memReadMEM,
  input  logic [REG_W-1:0] writeRegMEM,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexFlush,
  output logic             ifidFlush,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCycles
);
  logic             w_dep_ex;
  logic             w_dep_mem;
  logic             w_lu;
  logic             w_be;
  logic             w_bm;
  logic             w_md;
  logic             w_stall;
  logic [CNT_W-1:0] r_stall_cycles;

  assign w_dep_ex  = reg_match(useRsID, rsID, writeRegEX)  || reg_match(useRtID, rtID, writeRegEX);
  assign w_dep_mem = reg_match(useRsID, rsID, writeRegMEM) || reg_match(useRtID, rtID, writeRegMEM);

  // Branches compare in ID, so any EX producer (ALU or load) and a MEM load are too late to forward.
  assign w_lu    = memReadEX && w_dep_ex;
  assign w_be    = branchID && regWriteEX && w_dep_ex;
  assign w_bm    = branchID && memReadMEM && w_dep_mem;
  assign w_md    = (hiloReadID || mdStartID) && mdBusy;
  assign w_stall = w_lu || w_be || w_bm || w_md;

  md_countdown #(.MD_LATENCY(MD_LATENCY)) u_md_countdown (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (mdStartID && !w_stall),
    .o_busy (mdBusy)
  );

  // While reset is held the pipeline is frozen with a bubble entering EX.
  assign pcWrite   = rst_n && !w_stall;
  assign ifidWrite = rst_n && !w_stall;
  assign idexFlush = !rst_n || w_stall;
  assign ifidFlush = rst_n && !w_stall && branchTakenID;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stallCycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table plus multi-cycle sequences, scoreboard-checked.
module tb_hazard_stall_unit;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rsID, rtID, writeRegEX, writeRegMEM;
  logic       useRsID, useRtID, branchID, branchTakenID, mdStartID, hiloReadID;
  logic       regWriteEX, memReadEX, memReadMEM;
  logic       pcWrite, ifidWrite, idexFlush, ifidFlush, mdBusy;
  logic [CNT_W-1:0] stallCycles;

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rsID(rsID), .rtID(rtID), .useRsID(useRsID), .useRtID(useRtID),
    .branchID(branchID), .branchTakenID(branchTakenID), .mdStartID(mdStartID),
    .hiloReadID(hiloReadID), .regWriteEX(regWriteEX), .memReadEX(memReadEX),
    .writeRegEX(writeRegEX), .memReadMEM(memReadMEM), .writeRegMEM(writeRegMEM),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexFlush(idexFlush), .ifidFlush(ifidFlush),
    .mdBusy(mdBusy), .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic use_rs, use_rt, br, br_t, md_s, hilo, rw_ex, mr_ex;
    logic [4:0] wr_ex;
    logic mr_mem;
    logic [4:0] wr_mem;
  } in_t;
  typedef struct packed { logic pc, ifid, idex, ifl, busy; } exp_t;
  typedef struct packed { int tag; exp_t e; logic [CNT_W-1:0] cnt; } sb_t;
  typedef struct { in_t in; exp_t ex; } vec_t;

  // {pcWrite, ifidWrite, idexFlush, ifidFlush, mdBusy}
  localparam exp_t RUN  = 5'b11000;
  localparam exp_t RUNF = 5'b11010;
  localparam exp_t RUNB = 5'b11001;
  localparam exp_t STL  = 5'b00100;
  localparam exp_t STLB = 5'b00101;
  localparam exp_t RSTE = 5'b00100;

  sb_t q[$];
  vec_t tbl[11];
  int tests = 0;
  int failed = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic in_t mk(input logic [4:0] rs, rt, input logic urs, urt, br, brt, mds, hilo,
                             input logic rwex, mrex, input logic [4:0] wrex,
                             input logic mrmem, input logic [4:0] wrmem);
    in_t v;
    v = '{rs, rt, urs, urt, br, brt, mds, hilo, rwex, mrex, wrex, mrmem, wrmem};
    return v;
  endfunction

  task automatic apply(input in_t v);
    rsID = v.rs; rtID = v.rt; useRsID = v.use_rs; useRtID = v.use_rt;
    branchID = v.br; branchTakenID = v.br_t; mdStartID = v.md_s; hiloReadID = v.hilo;
    regWriteEX = v.rw_ex; memReadEX = v.mr_ex; writeRegEX = v.wr_ex;
    memReadMEM = v.mr_mem; writeRegMEM = v.wr_mem;
  endtask

  task automatic cmp(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL t%0d %s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask

  task automatic check_out();
    sb_t s;
    s = q.pop_front();
    cmp(s.tag, "pcWrite",     32'(pcWrite),     32'(s.e.pc));
    cmp(s.tag, "ifidWrite",   32'(ifidWrite),   32'(s.e.ifid));
    cmp(s.tag, "idexFlush",   32'(idexFlush),   32'(s.e.idex));
    cmp(s.tag, "ifidFlush",   32'(ifidFlush),   32'(s.e.ifl));
    cmp(s.tag, "mdBusy",      32'(mdBusy),      32'(s.e.busy));
    cmp(s.tag, "stallCycles", 32'(stallCycles), 32'(s.cnt));
    $display("[TB] t%0d pc=%b ifid=%b idexF=%b ifidF=%b busy=%b cnt=%0d", s.tag,
             pcWrite, ifidWrite, idexFlush, ifidFlush, mdBusy, stallCycles);
  endtask

  // One pipeline cycle: drive after the edge, sample mid-cycle, then advance the counter model.
  task automatic step(input in_t v, input exp_t e, input int tag);
    @(posedge clk); #1;
    apply(v);
    q.push_back('{tag, e, exp_cnt});
    #4;
    check_out();
    if (e.idex && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic reset_check(input int tag);
    q.push_back('{tag, RSTE, {CNT_W{1'b0}}});
    check_out();
  endtask

  in_t idle, lu8, hilo, mds;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0);
    lu8  = mk(8,0, 1,0, 0,0, 0,0, 1,1,8, 0,0);
    hilo = mk(0,0, 0,0, 0,0, 0,1, 0,0,0, 0,0);
    mds  = mk(4,5, 1,1, 0,0, 1,0, 0,0,0, 0,0);

    tbl[0]  = '{lu8, STL};                                           // load-use on rs
    tbl[1]  = '{mk(0,0, 1,0, 0,0, 0,0, 1,1,0, 0,0), RUN};            // $zero never matches
    tbl[2]  = '{mk(3,12, 0,1, 0,0, 0,0, 1,1,12, 0,0), STL};          // load-use on rt
    tbl[3]  = '{mk(3,12, 0,0, 0,0, 0,0, 1,1,12, 0,0), RUN};          // rt not read
    tbl[4]  = '{mk(5,0, 1,0, 0,0, 0,0, 1,0,5, 0,0), RUN};            // ALU result, forwardable
    tbl[5]  = '{mk(5,0, 1,0, 1,1, 0,0, 1,0,5, 0,0), STL};            // branch on EX ALU, taken masked
    tbl[6]  = '{mk(0,7, 0,1, 1,0, 0,0, 0,0,0, 1,7), STL};            // branch on MEM load
    tbl[7]  = '{mk(0,6, 0,1, 1,1, 0,0, 0,0,0, 1,7), RUNF};           // no match, taken flushes
    tbl[8]  = '{mk(1,2, 1,1, 1,1, 0,0, 0,0,0, 0,0), RUNF};
    tbl[9]  = '{hilo, RUN};                                          // HI/LO idle
    tbl[10] = '{idle, RUN};

    rst_n = 1'b0;
    apply(idle);
    #1;
    reset_check(0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) step(tbl[i].in, tbl[i].ex, 1 + i);

    // beq on a load in EX, then in MEM: two bubbles before the taken flush
    step(mk(9,0, 1,0, 1,1, 0,0, 1,1,9, 0,0), STL, 100);
    step(mk(9,0, 1,0, 1,1, 0,0, 0,0,0, 1,9), STL, 101);
    step(mk(9,0, 1,0, 1,1, 0,0, 0,0,0, 0,0), RUNF, 102);

    // mult then mfhi: held until the countdown expires
    step(mds, RUN, 200);
    for (int i = 0; i < 4; i++) step(hilo, STLB, 201 + i);
    step(hilo, RUN, 205);

    // taken branch coinciding with load-use: stall wins, flush once clear
    step(mk(8,0, 1,0, 0,1, 0,0, 1,1,8, 0,0), STL, 300);
    step(mk(8,0, 1,0, 0,1, 0,0, 0,0,0, 0,0), RUNF, 301);

    // reset in the middle of a countdown
    step(mds, RUN, 400);
    step(idle, RUNB, 401);
    step(mds, STLB, 402);
    @(posedge clk); #2;
    rst_n = 1'b0;
    apply(idle);
    #1;
    reset_check(403);
    exp_cnt = '0;
    @(posedge clk); #2;
    reset_check(404);
    rst_n = 1'b1;
    step(hilo, RUN, 405);

    // counter saturation
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step(lu8, STL, 500 + i);
    step(idle, RUN, 600);
    if (exp_cnt != '1) begin
      tests++;
      failed++;
      $display("FAIL satmodel: got %0d, expected %0d", exp_cnt, 15);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
